// File: rtl/seg7_decode_monitor.sv
// seg7_decode_monitor: synchronise, debounce and decode an active-low 7-segment pattern to a hex digit
// Ports: CLOCK_50 clock, Reset async active-high, SEG[0:6] segments a..g (active low),
//        Ready consumer accept, Valid/Value/Blank/Err decoded result, Overrun sticky overwrite flag,
//        ErrCount[7:0] saturating illegal-pattern count (only when SEG7_ERRCNT_EN is defined)
module seg7_decode_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic [0:6] SEG,
  input  logic       Ready,
  output logic       Valid,
  output logic [3:0] Value,
  output logic       Blank,
  output logic       Err,
  output logic       Overrun
`ifdef SEG7_ERRCNT_EN
  ,
  output logic [7:0] ErrCount
`endif
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [0:0] S_SETTLE = 1'b0;
  localparam logic [0:0] S_STABLE = 1'b1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  logic [SYNC_STAGES*7-1:0] sr;
  logic [0:6] s, s_prev, committed;
  logic [CW-1:0] cnt, cnt_next;
  logic [0:0] state;
  logic chg, commit;
  logic [5:0] d;
  function automatic logic [5:0] dec(input logic [0:6] p);
    case (p)
      7'b0000001: dec = 6'h00;
      7'b1001111: dec = 6'h01;
      7'b0010010: dec = 6'h02;
      7'b0000110: dec = 6'h03;
      7'b1001100: dec = 6'h04;
      7'b0100100: dec = 6'h05;
      7'b0100000: dec = 6'h06;
      7'b0001111: dec = 6'h07;
      7'b0000000: dec = 6'h08;
      7'b0000100: dec = 6'h09;
      7'b0001000: dec = 6'h0A;
      7'b1100000: dec = 6'h0B;
      7'b0110001: dec = 6'h0C;
      7'b1000010: dec = 6'h0D;
      7'b0110000: dec = 6'h0E;
      7'b0111000: dec = 6'h0F;
      7'b1111111: dec = 6'b010000;
      default:    dec = 6'b100000;
    endcase
  endfunction
  assign s = sr[SYNC_STAGES*7-1 -: 7];
  assign d = dec(s);
  always_comb begin
    chg = s != s_prev;
    cnt_next = chg ? CW'(1) : (cnt == CMAX ? cnt : cnt + CW'(1));
    // A commit fires only on entry to STABLE (or re-entry after a change) with a new pattern
    commit = cnt_next == CMAX && (state == S_SETTLE || chg) && s != committed;
  end
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      sr <= '1;
      s_prev <= '1;
      cnt <= '0;
      state <= S_SETTLE;
      committed <= '1;
      Valid <= 1'b0;
      Value <= 4'h0;
      Blank <= 1'b1;
      Err <= 1'b0;
      Overrun <= 1'b0;
`ifdef SEG7_ERRCNT_EN
      ErrCount <= 8'h00;
`endif
    end else begin
      sr <= {sr[SYNC_STAGES*7-8:0], SEG};
      s_prev <= s;
      cnt <= cnt_next;
      state <= cnt_next == CMAX ? S_STABLE : S_SETTLE;
      if (commit) begin
        committed <= s;
        {Err, Blank, Value} <= d;
        Valid <= 1'b1;
        if (Valid && !Ready) Overrun <= 1'b1;
`ifdef SEG7_ERRCNT_EN
        if (d[5] && ErrCount != 8'hFF) ErrCount <= ErrCount + 8'h01;
`endif
      end else if (Ready) begin
        Valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_decode_monitor.sv
// tb_seg7_decode_monitor: randomized and directed checks of seg7_decode_monitor against a sliding-window model
module tb_seg7_decode_monitor;
  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int HD = SYNC + STAB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:6] seg = 7'h7F;
  logic rdy = 1'b0;
  logic valid, blank, err, ovr;
  logic [3:0] value;
`ifdef SEG7_ERRCNT_EN
  logic [7:0] ec;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] codes [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [6:0] hist [HD];
  logic [6:0] m_com;
  logic m_valid, m_blank, m_err, m_ovr;
  logic [3:0] m_val;
  logic [7:0] m_ec;

  seg7_decode_monitor #(.STABLE_CYCLES(STAB), .SYNC_STAGES(SYNC)) dut (
    .CLOCK_50(clk), .Reset(rst), .SEG(seg), .Ready(rdy),
    .Valid(valid), .Value(value), .Blank(blank), .Err(err), .Overrun(ovr)
`ifdef SEG7_ERRCNT_EN
    , .ErrCount(ec)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < HD; i++) hist[i] = 7'h7F;
    m_com = 7'h7F;
    m_valid = 0; m_val = 0; m_blank = 1; m_err = 0; m_ovr = 0; m_ec = 0;
  endtask

  // One clock: a pattern is accepted once the SYNC-delayed window of STAB raw samples all agree
  task automatic tick();
    logic [6:0] sv;
    logic rv;
    logic ok;
    int idx;
    sv = seg;
    rv = rdy;
    @(posedge clk);
    for (int i = HD - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sv;
    ok = 1;
    for (int i = SYNC; i < HD; i++) if (hist[i] != hist[SYNC]) ok = 0;
    if (ok && hist[SYNC] != m_com) begin
      m_com = hist[SYNC];
      idx = -1;
      for (int i = 0; i < 16; i++) if (codes[i] == m_com) idx = i;
      m_blank = m_com == 7'h7F;
      m_err = idx < 0 && !m_blank;
      m_val = idx < 0 ? 4'h0 : 4'(idx);
      if (m_valid && !rv) m_ovr = 1;
      if (m_err && m_ec != 8'hFF) m_ec = m_ec + 1;
      m_valid = 1;
    end else if (rv) m_valid = 0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    n_chk++;
    if ({valid, value, blank, err, ovr} !== 8'b0_0000_100) begin
      n_fail++; $display("FAIL reset_outputs got %b want 000001 00", {valid, value, blank, err, ovr});
    end
`ifdef SEG7_ERRCNT_EN
    n_chk++;
    if (ec !== 8'h00) begin n_fail++; $display("FAIL reset_errcount got %h want 00", ec); end
`endif
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_latency();
    seg = 7'b0000001; rdy = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_chk++;
      if (valid !== (k == 5)) begin n_fail++; $display("FAIL latency edge %0d valid got %b want %b", k, valid, k == 5); end
    end
    n_chk++;
    if ({value, blank, err} !== 6'b0000_00) begin
      n_fail++; $display("FAIL latency_result got v=%h b=%b e=%b want 0 0 0", value, blank, err);
    end
  endtask

  task automatic test_glitch();
    rdy = 1; tick(); rdy = 0;
    seg = 7'b1001111;
    for (int k = 0; k < 3; k++) tick();
    seg = 7'b0000001;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_chk++;
      if (valid !== 0 || value !== 4'h0) begin
        n_fail++; $display("FAIL glitch cycle %0d got valid=%b value=%h want 0 0", k, valid, value);
      end
    end
  endtask

  task automatic test_sequence();
    int pulses;
    rdy = 1;
    seg = 7'h7F;
    for (int k = 0; k < 10; k++) tick();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      seg = codes[i];
      for (int k = 0; k < 10; k++) begin
        tick();
        if (valid) begin
          pulses++;
          n_chk++;
          if (value !== 4'(i) || err !== 0 || blank !== 0) begin
            n_fail++; $display("FAIL seq_value got %h e=%b b=%b want %h", value, err, blank, i);
          end
        end
      end
    end
    n_chk++;
    if (pulses != 16) begin n_fail++; $display("FAIL seq_pulses got %0d want 16", pulses); end
    n_chk++;
    if (ovr !== 0) begin n_fail++; $display("FAIL seq_overrun got %b want 0", ovr); end
  endtask

  task automatic test_err();
    do_reset();
    rdy = 0;
    seg = 7'b1111110;
    for (int k = 0; k < 8; k++) tick();
    n_chk++;
    if ({valid, err, blank, value} !== 7'b1_1_0_0000) begin
      n_fail++; $display("FAIL err_result got v=%b e=%b b=%b val=%h want 1 1 0 0", valid, err, blank, value);
    end
`ifdef SEG7_ERRCNT_EN
    n_chk++;
    if (ec !== 8'h01) begin n_fail++; $display("FAIL errcount_one got %h want 01", ec); end
`endif
    rdy = 1;
    for (int j = 0; j < 300; j++) begin
      seg = j[0] ? 7'b1111110 : 7'b1111101;
      for (int k = 0; k < 6; k++) tick();
    end
    n_chk++;
    if (err !== 1 || value !== 4'h0) begin n_fail++; $display("FAIL err_repeat got e=%b val=%h want 1 0", err, value); end
`ifdef SEG7_ERRCNT_EN
    n_chk++;
    if (ec !== 8'hFF) begin n_fail++; $display("FAIL errcount_sat got %h want ff", ec); end
`endif
  endtask

  task automatic test_overrun();
    rdy = 0;
    seg = codes[2];
    for (int k = 0; k < 8; k++) tick();
    seg = codes[3];
    for (int k = 0; k < 8; k++) tick();
    n_chk++;
    if ({valid, value, ovr} !== 6'b1_0011_1) begin
      n_fail++; $display("FAIL overrun got v=%b val=%h o=%b want 1 3 1", valid, value, ovr);
    end
    rdy = 1; tick(); rdy = 0;
    n_chk++;
    if (valid !== 0 || ovr !== 1) begin n_fail++; $display("FAIL overrun_accept got v=%b o=%b want 0 1", valid, ovr); end
  endtask

  task automatic test_reset_mid();
    seg = codes[5];
    for (int k = 0; k < 4; k++) tick();
    do_reset();
    seg = 7'h7F;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_chk++;
      if (valid !== 0) begin n_fail++; $display("FAIL blank_after_reset cycle %0d valid got %b want 0", k, valid); end
    end
  endtask

  task automatic test_random();
    int hold;
    int r;
    for (int j = 0; j < 150; j++) begin
      r = int'($urandom_range(0, 9));
      seg = r < 6 ? codes[$urandom_range(0, 15)] : (r < 8 ? 7'h7F : 7'($urandom));
      hold = int'($urandom_range(1, 8));
      for (int k = 0; k < hold; k++) begin
        rdy = 1'($urandom);
        tick();
        n_chk++;
        if ({valid, value, blank, err, ovr} !== {m_valid, m_val, m_blank, m_err, m_ovr}) begin
          n_fail++;
          $display("FAIL random got v=%b val=%h b=%b e=%b o=%b want v=%b val=%h b=%b e=%b o=%b",
                   valid, value, blank, err, ovr, m_valid, m_val, m_blank, m_err, m_ovr);
        end
`ifdef SEG7_ERRCNT_EN
        n_chk++;
        if (ec !== m_ec) begin n_fail++; $display("FAIL random_errcount got %h want %h", ec, m_ec); end
`endif
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_sequence();
    test_err();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
